// File: rtl/super_i3_bch_outer_page_sched.sv
// -----------------------------------------------------------------------------
// super_i3_bch_outer_page_sched
//
// Two-page (ping-pong) buffer scheduler for the I.3 outer BCH(3860,3824)
// decoder array. It tracks which RAM page the syndrome counter is filling and
// hands pages with complete syndromes to the shared BM/Chien decoder in frame
// order. It then reads corrected pages out of the RAM in order, for the output
// framer, and back-pressures the frame source when no page is free.
//
// Page life cycle: FREE -> FILL -> FULL -> DEC -> DONE -> FREE.
//
// Optional feature macro: SUPER_I3_BCH_OUTER_PAGE_SCHED_STAT_EN
//   defined   : ofrm_in_cnt / ofrm_out_cnt count accepted and read-out frames
//   undefined : both count ports are tied to zero
//
// Ports
//   iclk, ireset        clock, asynchronous active-high reset
//   iclkena             clock enable; all state advances only when high
//   isop, ival          frame start / word valid snooped from syndrome counter
//   ordy                next page is free, a new frame may start
//   isyndrome_val/_ptr  syndromes of a page complete (pulse) and that page
//   idec_rdy            decoder can accept a page
//   odec_start/_ptr     decode start pulse and page to decode
//   idec_done/_ptr      decoder finished a page (pulse) and that page
//   iordy               downstream accepts readout words
//   oram_read/_rptr/_raddr  RAM read strobe, page and word address
//   oval, osop, oeop    readout framing, aligned with RAM read data
//   oerr[2:0]           sticky: [0] isop while !ordy, [1] syndrome on non-FILL
//                       page, [2] dec_done on non-DEC page
//   ofrm_in_cnt/_out_cnt    frame statistics (optional)
// -----------------------------------------------------------------------------
module super_i3_bch_outer_page_sched #(
   parameter int pADDR_W      = 8,
   parameter int pFRAME_WORDS = 242,
   parameter int pRAM_RD_LAT  = 2
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic               isop,
   input  logic               ival,
   output logic               ordy,
   input  logic               isyndrome_val,
   input  logic               isyndrome_ptr,
   input  logic               idec_rdy,
   output logic               odec_start,
   output logic               odec_ptr,
   input  logic               idec_done,
   input  logic               idec_ptr,
   input  logic               iordy,
   output logic               oram_read,
   output logic               oram_rptr,
   output logic [pADDR_W-1:0] oram_raddr,
   output logic               oval,
   output logic               osop,
   output logic               oeop,
   output logic [2:0]         oerr,
   output logic [15:0]        ofrm_in_cnt,
   output logic [15:0]        ofrm_out_cnt
);

   localparam logic [pADDR_W-1:0] cLAST_ADDR = pADDR_W'(pFRAME_WORDS - 1);

   typedef enum logic [2:0] {PG_FREE, PG_FILL, PG_FULL, PG_DEC, PG_DONE} page_state_t;
   typedef enum logic       {RD_IDLE, RD_RUN}                            rd_state_t;

   page_state_t        page_state [2];
   logic               wptr;
   logic               dec_head;
   logic               rd_head;
   logic               frm_accept;
   logic               dec_go;

   rd_state_t          rd_state, rd_state_nxt;
   logic [pADDR_W-1:0] raddr, raddr_nxt;
   logic               rd_strobe;
   logic               rd_free;

   logic [pRAM_RD_LAT-1:0] val_dly, sop_dly, eop_dly;

   // The page the next frame would claim is the one not currently written.
   assign ordy       = (page_state[~wptr] == PG_FREE);
   assign frm_accept = isop & ival & ordy;
   // odec_start in the term keeps at least one cycle between two starts, so
   // the decoder always gets a chance to drop idec_rdy after a start.
   assign dec_go     = (page_state[dec_head] == PG_FULL) & idec_rdy & ~odec_start;

   //---------------------------------------------------------------------------
   // Page state, pointers, decode start and sticky errors
   //---------------------------------------------------------------------------
   // Every page transition requires a distinct current state, so at most one
   // of the branches below writes a given page in any cycle.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         // NOTE: page_state is a two-entry register array, not a RAM, so it is
         // reset like any other flop; a reset mid-frame discards both pages.
         page_state[0] <= PG_FREE;
         page_state[1] <= PG_FREE;
         wptr          <= 1'b0;
         dec_head      <= 1'b1;
         rd_head       <= 1'b1;
         odec_start    <= 1'b0;
         odec_ptr      <= 1'b0;
         oerr          <= '0;
      end else if (iclkena) begin
         // NOTE: non-blocking assignments throughout sequential blocks, so every
         // branch sees the state as registered at the start of the cycle.
         odec_start <= 1'b0;

         if (isop & ival) begin
            if (ordy) begin
               page_state[~wptr] <= PG_FILL;
               wptr              <= ~wptr;
            end else begin
               oerr[0] <= 1'b1;
            end
         end

         if (isyndrome_val) begin
            if (page_state[isyndrome_ptr] == PG_FILL) page_state[isyndrome_ptr] <= PG_FULL;
            else                                      oerr[1] <= 1'b1;
         end

         if (dec_go) begin
            odec_start           <= 1'b1;
            odec_ptr             <= dec_head;
            page_state[dec_head] <= PG_DEC;
            dec_head             <= ~dec_head;
         end

         if (idec_done) begin
            if (page_state[idec_ptr] == PG_DEC) page_state[idec_ptr] <= PG_DONE;
            else                                oerr[2] <= 1'b1;
         end

         if (rd_free) begin
            page_state[rd_head] <= PG_FREE;
            rd_head             <= ~rd_head;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Readout FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         rd_state <= RD_IDLE;
         raddr    <= '0;
      end else if (iclkena) begin
         rd_state <= rd_state_nxt;
         raddr    <= raddr_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      rd_state_nxt = rd_state;
      raddr_nxt    = raddr;
      rd_strobe    = 1'b0;
      rd_free      = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (page_state[rd_head] == PG_DONE) begin
               rd_state_nxt = RD_RUN;
               raddr_nxt    = '0;
            end
         end
         RD_RUN: begin
            rd_strobe = iordy & iclkena;
            if (rd_strobe) begin
               raddr_nxt = raddr + 1'b1;
               if (raddr == cLAST_ADDR) begin
                  rd_free      = 1'b1;
                  rd_state_nxt = RD_IDLE;
               end
            end
         end
      endcase
   end

   assign oram_read  = rd_strobe;
   assign oram_rptr  = (rd_state == RD_RUN) & rd_head;
   assign oram_raddr = (rd_state == RD_RUN) ? raddr : '0;

   //---------------------------------------------------------------------------
   // Framing tags follow the read strobe through the RAM latency. The delay
   // line never stalls: words already in flight complete after iordy drops.
   //---------------------------------------------------------------------------
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         val_dly <= '0;
         sop_dly <= '0;
         eop_dly <= '0;
      end else if (iclkena) begin
         val_dly[0] <= rd_strobe;
         sop_dly[0] <= rd_strobe & (raddr == '0);
         eop_dly[0] <= rd_strobe & (raddr == cLAST_ADDR);
         for (int i = 1; i < pRAM_RD_LAT; i++) begin
            val_dly[i] <= val_dly[i-1];
            sop_dly[i] <= sop_dly[i-1];
            eop_dly[i] <= eop_dly[i-1];
         end
      end
   end

   assign oval = val_dly[pRAM_RD_LAT-1];
   assign osop = sop_dly[pRAM_RD_LAT-1];
   assign oeop = eop_dly[pRAM_RD_LAT-1];

   //---------------------------------------------------------------------------
   // Optional frame statistics
   //---------------------------------------------------------------------------
`ifdef SUPER_I3_BCH_OUTER_PAGE_SCHED_STAT_EN
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         ofrm_in_cnt  <= '0;
         ofrm_out_cnt <= '0;
      end else if (iclkena) begin
         if (frm_accept) ofrm_in_cnt  <= ofrm_in_cnt + 16'd1;
         if (rd_free)    ofrm_out_cnt <= ofrm_out_cnt + 16'd1;
      end
   end
`else
   assign ofrm_in_cnt  = '0;
   assign ofrm_out_cnt = '0;
`endif

endmodule

// File: tb/tb_super_i3_bch_outer_page_sched.sv
// -----------------------------------------------------------------------------
// Testbench for super_i3_bch_outer_page_sched.
//
// A background environment process plays the decoder and the downstream
// framer. It records every RAM read, every output word and every decode start,
// and it checks ordy each cycle against a frame-occupancy model: the design
// may hold at most two frames that have been accepted but not yet read out.
// The scenario tasks drive frames and compare the recorded traffic with the
// behaviour expected of the design. Frames use pages 1,0,1,... from reset;
// each frame reads out 0..241 and its framing appears two cycles later.
// -----------------------------------------------------------------------------
module tb_super_i3_bch_outer_page_sched;

   localparam int FW   = 242;
   localparam int LAT  = 2;
   localparam int LAST = FW - 1;

   typedef struct {int cyc; bit pg; int addr;} rd_t;
   typedef struct {int cyc; bit sop; bit eop;} ov_t;

   logic       iclk = 1'b0;
   logic       ireset, iclkena, isop, ival, ordy;
   logic       isyndrome_val, isyndrome_ptr, idec_rdy, odec_start, odec_ptr;
   logic       idec_done, idec_ptr, iordy, oram_read, oram_rptr;
   logic [7:0] oram_raddr;
   logic       oval, osop, oeop;
   logic [2:0] oerr;
   logic [15:0] ofrm_in_cnt, ofrm_out_cnt;

   super_i3_bch_outer_page_sched dut (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
      .ordy(ordy), .isyndrome_val(isyndrome_val), .isyndrome_ptr(isyndrome_ptr),
      .idec_rdy(idec_rdy), .odec_start(odec_start), .odec_ptr(odec_ptr),
      .idec_done(idec_done), .idec_ptr(idec_ptr), .iordy(iordy),
      .oram_read(oram_read), .oram_rptr(oram_rptr), .oram_raddr(oram_raddr),
      .oval(oval), .osop(osop), .oeop(oeop), .oerr(oerr),
      .ofrm_in_cnt(ofrm_in_cnt), .ofrm_out_cnt(ofrm_out_cnt)
   );

   always #5 iclk = ~iclk;

   int  errors = 0;
   int  checks = 0;
   int  cyc    = 0;
   int  n_acc  = 0;
   int  n_free = 0;
   bit  exp_wr_page = 1'b1;
   rd_t rd_q [$];
   ov_t ov_q [$];
   bit  dec_q [$];

   // environment controls
   bit  dec_rdy_en = 1'b1;
   bit  dec_rand   = 1'b0;
   int  dec_lat    = 3;
   int  iordy_mode = 0;
   bit  inj_done   = 1'b0;
   bit  inj_ptr    = 1'b0;

   // environment: drive at the falling edge, sample 2 ns later
   initial begin
      bit  nxt_iordy, nxt_rdy, nxt_done, nxt_dptr, dec_busy, dec_cur;
      int  dec_cnt;
      rd_t r;
      ov_t o;
      nxt_iordy = 0; nxt_rdy = 0; nxt_done = 0; nxt_dptr = 0;
      dec_busy  = 0; dec_cur = 0; dec_cnt = 0;
      forever begin
         @(negedge iclk);
         iordy = nxt_iordy; idec_rdy = nxt_rdy; idec_done = nxt_done; idec_ptr = nxt_dptr;
         #2;
         cyc++;
         nxt_done = 1'b0;
         if (ireset !== 1'b0) begin
            dec_busy = 0; nxt_iordy = 0; nxt_rdy = 0;
         end else begin
            if (oram_read === 1'b1) begin
               r.cyc = cyc; r.pg = oram_rptr; r.addr = int'(oram_raddr);
               rd_q.push_back(r);
            end
            if (oval === 1'b1) begin
               o.cyc = cyc; o.sop = osop; o.eop = oeop;
               ov_q.push_back(o);
            end
            checks++;
            if (ordy !== ((n_acc - n_free) < 2)) begin
               errors++;
               $display("FAIL ordy_model cyc=%0d got=%b exp=%b", cyc, ordy, ((n_acc - n_free) < 2));
            end
            if (isop === 1'b1 && ival === 1'b1 && ordy === 1'b1) n_acc++;
            if (oram_read === 1'b1 && int'(oram_raddr) == LAST) n_free++;
            if (odec_start === 1'b1) begin
               checks++;
               if (dec_busy) begin
                  errors++;
                  $display("FAIL dec_start_while_busy cyc=%0d got=1 exp=0", cyc);
               end
               dec_q.push_back(odec_ptr);
               dec_busy = 1; dec_cur = odec_ptr;
               dec_cnt  = dec_rand ? int'($urandom_range(1, 8)) : dec_lat;
            end else if (dec_busy) begin
               dec_cnt--;
               if (dec_cnt <= 0) begin
                  nxt_done = 1'b1; nxt_dptr = dec_cur; dec_busy = 0;
               end
            end
            if (inj_done) begin
               nxt_done = 1'b1; nxt_dptr = inj_ptr; inj_done = 1'b0;
            end
            nxt_rdy = dec_rdy_en && !dec_busy && (!dec_rand || ($urandom_range(0, 1) == 1));
            case (iordy_mode)
               0:       nxt_iordy = 1'b1;
               1:       nxt_iordy = !iordy;
               default: nxt_iordy = ($urandom_range(0, 1) == 1);
            endcase
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      ireset = 1'b1; iclkena = 1'b1; isop = 0; ival = 0;
      isyndrome_val = 0; isyndrome_ptr = 0;
      dec_rdy_en = 1; dec_rand = 0; dec_lat = 3; iordy_mode = 0; inj_done = 0;
      repeat (3) @(negedge iclk);
      rd_q.delete(); ov_q.delete(); dec_q.delete();
      n_acc = 0; n_free = 0; exp_wr_page = 1'b1;
      ireset = 1'b0;
   endtask

   task automatic wait_ordy();
      int budget = 20000;
      while (ordy !== 1'b1 && budget > 0) begin
         @(negedge iclk);
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL ordy_timeout got=%b exp=1", ordy);
      end
   endtask

   // One frame: isop with the first word, FW words total, then the
   // syndrome-complete pulse for the page this frame was written to.
   task automatic send_frame(input bit gaps);
      bit pg;
      int w;
      wait_ordy();
      pg = exp_wr_page;
      exp_wr_page = ~exp_wr_page;
      isop = 1'b1; ival = 1'b1;
      w = 1;
      while (w < FW) begin
         @(negedge iclk);
         isop = 1'b0;
         if (gaps && $urandom_range(0, 3) == 0) ival = 1'b0;
         else begin
            ival = 1'b1;
            w++;
         end
      end
      @(negedge iclk);
      ival = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge iclk);
      isyndrome_val = 1'b1; isyndrome_ptr = pg;
      @(negedge iclk);
      isyndrome_val = 1'b0;
   endtask

   task automatic wait_reads(input int nfr);
      int budget = 20000;
      while (ov_q.size() < nfr * FW && budget > 0) begin
         @(negedge iclk);
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL readout_timeout got=%0d exp=%0d words", ov_q.size(), nfr * FW);
      end
      repeat (20) @(negedge iclk);
   endtask

   task automatic check_dec(input int nfr);
      checks++;
      if (dec_q.size() != nfr) begin
         errors++;
         $display("FAIL dec_count got=%0d exp=%0d", dec_q.size(), nfr);
      end
      for (int i = 0; i < dec_q.size() && i < nfr; i++) begin
         checks++;
         if (dec_q[i] !== (1'b1 ^ i[0])) begin
            errors++;
            $display("FAIL dec_order idx=%0d got=%b exp=%b", i, dec_q[i], (1'b1 ^ i[0]));
         end
      end
   endtask

   task automatic check_readout(input int nfr);
      int n = nfr * FW;
      int ea;
      bit ep;
      checks++;
      if (rd_q.size() != n) begin
         errors++;
         $display("FAIL read_count got=%0d exp=%0d", rd_q.size(), n);
      end
      checks++;
      if (ov_q.size() != n) begin
         errors++;
         $display("FAIL oval_count got=%0d exp=%0d", ov_q.size(), n);
      end
      for (int i = 0; i < rd_q.size() && i < ov_q.size() && i < n; i++) begin
         ea = i % FW;
         ep = ((i / FW) % 2 == 0);
         checks++;
         if (rd_q[i].addr != ea || rd_q[i].pg !== ep) begin
            errors++;
            $display("FAIL read_seq idx=%0d got=p%0d/a%0d exp=p%0d/a%0d", i, rd_q[i].pg, rd_q[i].addr, ep, ea);
         end
         checks++;
         if (ov_q[i].cyc != rd_q[i].cyc + LAT || ov_q[i].sop !== (ea == 0) || ov_q[i].eop !== (ea == LAST)) begin
            errors++;
            $display("FAIL out_frame idx=%0d got=dly%0d/sop%b/eop%b exp=dly%0d/sop%b/eop%b", i,
                     ov_q[i].cyc - rd_q[i].cyc, ov_q[i].sop, ov_q[i].eop, LAT, (ea == 0), (ea == LAST));
         end
      end
   endtask

   task automatic check_oerr(input string name, input logic [2:0] exp);
      checks++;
      if (oerr !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, oerr, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge iclk); #1;
      checks++; if (ordy !== 1'b1)       begin errors++; $display("FAIL reset_ordy got=%b exp=1", ordy); end
      checks++; if (odec_start !== 1'b0) begin errors++; $display("FAIL reset_dec_start got=%b exp=0", odec_start); end
      checks++; if (odec_ptr !== 1'b0)   begin errors++; $display("FAIL reset_dec_ptr got=%b exp=0", odec_ptr); end
      checks++; if (oram_read !== 1'b0)  begin errors++; $display("FAIL reset_ram_read got=%b exp=0", oram_read); end
      checks++; if (oram_rptr !== 1'b0)  begin errors++; $display("FAIL reset_ram_rptr got=%b exp=0", oram_rptr); end
      checks++; if (oram_raddr !== 8'd0) begin errors++; $display("FAIL reset_ram_raddr got=%0d exp=0", oram_raddr); end
      checks++; if ({oval, osop, oeop} !== 3'b000) begin errors++; $display("FAIL reset_framing got=%b exp=000", {oval, osop, oeop}); end
      check_oerr("reset_oerr", 3'b000);
      checks++;
      if (ofrm_in_cnt !== 16'd0 || ofrm_out_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_stat got=%0d/%0d exp=0/0", ofrm_in_cnt, ofrm_out_cnt);
      end
   endtask

   task automatic test_single_frame();
      do_reset();
      send_frame(1'b0);
      wait_reads(1);
      check_dec(1);
      check_readout(1);
      check_oerr("single_oerr", 3'b000);
   endtask

   task automatic test_back_to_back();
      do_reset();
      dec_rdy_en = 1'b0;
      send_frame(1'b0);
      send_frame(1'b0);
      #1;
      checks++;
      if (ordy !== 1'b0) begin errors++; $display("FAIL b2b_ordy_low got=%b exp=0", ordy); end
      @(negedge iclk);
      isop = 1'b1; ival = 1'b1;
      @(negedge iclk);
      isop = 1'b0; ival = 1'b0;
      @(negedge iclk); #1;
      check_oerr("b2b_overrun_oerr", 3'b001);
      repeat (10) @(negedge iclk);
      checks++;
      if (dec_q.size() != 0) begin errors++; $display("FAIL b2b_dec_blocked got=%0d exp=0", dec_q.size()); end
      dec_rdy_en = 1'b1;
      wait_reads(2);
      check_dec(2);
      check_readout(2);
      check_oerr("b2b_oerr_sticky", 3'b001);
   endtask

   task automatic test_iordy_toggle();
      do_reset();
      iordy_mode = 1;
      send_frame(1'b1);
      wait_reads(1);
      check_dec(1);
      check_readout(1);
   endtask

   task automatic test_syn_err();
      do_reset();
      @(negedge iclk);
      isyndrome_val = 1'b1; isyndrome_ptr = 1'b0;
      @(negedge iclk);
      isyndrome_val = 1'b0;
      @(negedge iclk); #1;
      check_oerr("syn_err_oerr", 3'b010);
      inj_ptr = 1'b1; inj_done = 1'b1;
      repeat (4) @(negedge iclk);
      check_oerr("done_err_oerr", 3'b110);
      repeat (20) @(negedge iclk);
      checks++;
      if (dec_q.size() != 0 || rd_q.size() != 0) begin
         errors++;
         $display("FAIL syn_err_no_activity got=%0d/%0d exp=0/0", dec_q.size(), rd_q.size());
      end
      send_frame(1'b0);
      wait_reads(1);
      check_dec(1);
      check_readout(1);
   endtask

   task automatic test_reset_mid_readout();
      int budget = 5000;
      do_reset();
      send_frame(1'b0);
      while (rd_q.size() < 101 && budget > 0) begin
         @(negedge iclk); #3;
         budget--;
      end
      checks++;
      if (budget == 0 || rd_q[100].addr != 100) begin
         errors++;
         $display("FAIL mid_reach_addr100 got=%0d exp=101 reads", rd_q.size());
      end
      checks++;
      if (oval !== 1'b1) begin errors++; $display("FAIL mid_oval_before got=%b exp=1", oval); end
      ireset = 1'b1;
      #1;
      checks++; if (oval !== 1'b0)      begin errors++; $display("FAIL mid_oval_cleared got=%b exp=0", oval); end
      checks++; if (oram_read !== 1'b0) begin errors++; $display("FAIL mid_read_cleared got=%b exp=0", oram_read); end
      checks++; if (ordy !== 1'b1)      begin errors++; $display("FAIL mid_ordy got=%b exp=1", ordy); end
      check_oerr("mid_oerr", 3'b000);
      repeat (2) @(negedge iclk);
      do_reset();
      send_frame(1'b0);
      wait_reads(1);
      check_dec(1);
      check_readout(1);
   endtask

   task automatic test_random_frames();
      int exp_cnt;
      do_reset();
      iordy_mode = 2;
      dec_rand   = 1'b1;
      for (int f = 0; f < 5; f++) send_frame(1'b1);
      wait_reads(5);
      check_dec(5);
      check_readout(5);
      check_oerr("random_oerr", 3'b000);
`ifdef SUPER_I3_BCH_OUTER_PAGE_SCHED_STAT_EN
      exp_cnt = 5;
`else
      exp_cnt = 0;
`endif
      checks++;
      if (ofrm_in_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stat_in got=%0d exp=%0d", ofrm_in_cnt, exp_cnt); end
      checks++;
      if (ofrm_out_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stat_out got=%0d exp=%0d", ofrm_out_cnt, exp_cnt); end
   endtask

   initial begin
      ireset = 1'b1; iclkena = 1'b1; isop = 0; ival = 0;
      isyndrome_val = 0; isyndrome_ptr = 0;
      iordy = 0; idec_rdy = 0; idec_done = 0; idec_ptr = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_iordy_toggle();
      test_syn_err();
      test_reset_mid_readout();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
